unsigned_mul_add: RTL and testbench
===================================

# unsigned_mul_add

Sequential shift-add unsigned multiplier with accumulate: computes result = multiplicand × multiplier + addend over N+2 busy cycles, one product bit per cycle. It is the inverse companion to the team's sequential unsigned divider: feeding it the divider's divisor, quotient and remainder reconstructs the original dividend. It uses the same valid/ready pulse handshake, so both blocks can sit side by side in the arithmetic datapath and self-check loops.

## Interface
- N, default 8, operand width; N ≥ 2.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- valid  in  1  start request; sampled only in IDLE.
- multiplicand  in  N  unsigned operand A.
- multiplier  in  N  unsigned operand B.
- addend  in  N  unsigned operand C, added after the product.
- busy  out  1  high while in OP or ADD.
- ready  out  1  one-cycle completion pulse; high only in DONE.
- result  out  2N  A×B+C; holds its value until the next DONE.

## Operation
- States and transitions:
  - IDLE: if valid, go to OP; otherwise stay in IDLE.
  - OP: go to ADD when the step counter has completed N steps; otherwise stay in OP.
  - ADD: go to DONE.
  - DONE: go to IDLE.
  - Illegal encoding: go to IDLE.
- Capture (IDLE, valid=1): register A, B and C into internal regs; hi←0 (N+1 bits, includes carry); lo←B; count←0.
- OP step, one per cycle:
  - If lo[0]=1, sum = hi + A (N+1 bits); otherwise sum = hi.
  - Shift {sum, lo} right by 1, then keep the low 2N+1 bits into {hi, lo}.
  - count←count+1.
- ADD: P = {hi[N-1:0], lo} + zero-extended C. Width rule: the maximum value (2^N−1)²+(2^N−1) = 2^2N−2^N, so the sum never exceeds 2N bits and no overflow flag is needed.
- DONE: result←P; ready=1.
- Input isolation: operand inputs and valid are ignored outside IDLE. Input changes during OP or ADD must not affect the result.
- Reset values: state IDLE; ready 0; busy 0; result 0; internal regs and count 0.
- Reset mid-operation aborts the computation: no ready pulse, result returns to 0.
- Zero operands need no special case: A=0 or B=0 gives result = C.

## Timing
- Start edge: the edge that samples valid=1 in IDLE is edge 0.
- Busy: high from after edge 0 until after edge N+1 (covering the N OP cycles plus ADD).
- ready: high for exactly the one cycle between edges N+1 and N+2.
- result: updates at edge N+2 (the edge leaving DONE's register write); it is registered, no combinational path from inputs.
- Latency: valid sample to ready asserted is N+1 edges.
- Throughput with valid held high: one operation per N+3 cycles. DONE always returns to IDLE; the next valid is sampled in IDLE.
- valid and ready may be high in the same cycle only if valid is asserted during DONE; it is not acted on until IDLE.

## Structure
- Shared package unsigned_arith_pkg:
  - State encoding localparams IDLE=0, OP=1, ADD=2, DONE=3 (2-bit).
  - Counter width function clog2(N+1).
- The divider uses the same package.
- Sub-module shift_add_step: combinational, (hi, lo, A) → (hi', lo'). Single instance, registered in the parent.
- Two always blocks: an async-reset state/datapath register block and a combinational next-state block.

## Test plan
- N=8; A=13, B=11, C=7, valid for 1 cycle → ready pulses 9 edges later (N+1), result=0x0096; busy high for 9 cycles.
- A=255, B=255, C=255 → result=0xFF00 (max case, no overflow); A=0, B=200, C=0 → result=0x0000.
- Divider round-trip: dividend 200, divisor 7 → quotient 28, remainder 4; feeding A=7, B=28, C=4 → result=200.
- valid held high for 40 cycles with a fixed operand set → ready every 11 cycles (N+3), identical result each time. Changing operands mid-OP → in-flight result unchanged, new operands used on the next op.
- RST asserted at OP cycle 4, then released → busy=0, ready never pulses, result=0. A new op after release is correct: A=3, B=5, C=1 → 16.

Source files
------------

// File: rtl/unsigned_arith_pkg.sv
// -----------------------------------------------------------------------------
// unsigned_arith_pkg
//   Definitions shared by the sequential unsigned arithmetic blocks
//   (unsigned_mul_add and its companion divider).
//   - 2-bit FSM state encodings, kept as plain localparams so older blocks
//     that compare against raw codes keep working.
//   - clog2: counter width helper, evaluated at elaboration time.
// -----------------------------------------------------------------------------
package unsigned_arith_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OP   = 2'd1;
  localparam logic [1:0] ADD  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Number of bits needed to count from 0 to value-1; never returns less
  // than 1 so a counter declared with it always has at least one bit.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    if (bits < 1) bits = 1;
    return bits;
  endfunction

endpackage

// File: rtl/unsigned_mul_add_shift_add_step.sv
// -----------------------------------------------------------------------------
// shift_add_step
//   One combinational step of the shift-add multiplier. If the current
//   multiplier bit (lo[0]) is set, the multiplicand is added to the upper
//   partial product; the {sum, lo} pair is then shifted right by one.
//
//   Ports
//     hi           in  N+1  upper partial product (bit N is the carry slot)
//     lo           in  N    lower partial product / remaining multiplier bits
//     multiplicand in  N    operand A
//     hi_next      out N+1  upper partial product after the step
//     lo_next      out N    lower partial product after the step
// -----------------------------------------------------------------------------
module shift_add_step #(
  parameter int N = 8
) (
  input  logic [N:0]   hi,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] multiplicand,
  output logic [N:0]   hi_next,
  output logic [N-1:0] lo_next
);

  logic [N:0] sum;

  always_comb begin
    // hi is always below 2^N between steps, so hi + A fits in N+1 bits.
    sum = lo[0] ? (hi + {1'b0, multiplicand}) : hi;
    // The shifted-in top bit is always zero; the sum's LSB falls into lo.
    hi_next = {1'b0, sum[N:1]};
    lo_next = {sum[0], lo[N-1:1]};
  end

endmodule

// File: rtl/unsigned_mul_add.sv
// -----------------------------------------------------------------------------
// unsigned_mul_add
//   Sequential shift-add multiplier with accumulate: result = A*B + C.
//   One product bit per cycle over N OP cycles, followed by one ADD cycle
//   and a one-cycle DONE completion pulse. Feeding it a divider's divisor,
//   quotient and remainder rebuilds the dividend.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting; samples valid and captures operands
//   OP    | one shift-add step per cycle, N cycles
//   ADD   | product complete; addend sum formed combinationally
//   DONE  | ready pulse; result register loads the final sum
//
//   Ports
//     CLK          in  1   clock, rising edge
//     RST          in  1   asynchronous reset, active high
//     valid        in  1   start request, only looked at in IDLE
//     multiplicand in  N   operand A
//     multiplier   in  N   operand B
//     addend       in  N   operand C
//     busy         out 1   high in OP and ADD
//     ready        out 1   high for the single DONE cycle
//     result       out 2N  A*B+C, held until the next DONE
// -----------------------------------------------------------------------------
module unsigned_mul_add
  import unsigned_arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           valid,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  input  logic [N-1:0]   addend,
  output logic           busy,
  output logic           ready,
  output logic [2*N-1:0] result
);

  localparam int CNT_W = clog2(N + 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [N-1:0]     a_reg;
  logic [N-1:0]     c_reg;
  logic [N:0]       hi;
  logic [N-1:0]     lo;
  logic [CNT_W-1:0] count;

  logic [N:0]       hi_step;
  logic [N-1:0]     lo_step;
  logic [2*N-1:0]   product_sum;

  shift_add_step #(.N(N)) u_step (
    .hi           (hi),
    .lo           (lo),
    .multiplicand (a_reg),
    .hi_next      (hi_step),
    .lo_next      (lo_step)
  );

  // hi[N] is always zero once the N steps are done, and A*B + C is at most
  // 2^2N - 2^N, so the 2N-bit sum cannot overflow.
  assign product_sum = {hi[N-1:0], lo} + {{N{1'b0}}, c_reg};

  assign busy  = (state == OP) || (state == ADD);
  assign ready = (state == DONE);

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = valid ? OP : IDLE;
      // The step taken on this edge is the Nth one.
      OP:      state_next = (count == CNT_W'(N - 1)) ? ADD : OP;
      ADD:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      a_reg  <= '0;
      c_reg  <= '0;
      hi     <= '0;
      lo     <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (valid) begin
            a_reg <= multiplicand;
            c_reg <= addend;
            hi    <= '0;
            lo    <= multiplier;
            count <= '0;
          end
        end
        OP: begin
          hi    <= hi_step;
          lo    <= lo_step;
          count <= count + CNT_W'(1);
        end
        // hi/lo/c_reg stay frozen through ADD and DONE, so the sum seen
        // while leaving DONE is the one formed in ADD.
        DONE:    result <= product_sum;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_mul_add.sv
// -----------------------------------------------------------------------------
// tb_unsigned_mul_add
//   Self-checking bench for unsigned_mul_add with N = 8. A negedge monitor
//   keeps a scoreboard: every start the DUT accepts pushes the modelled
//   A*B+C, and every completion pops and compares it against result.
// -----------------------------------------------------------------------------
module tb_unsigned_mul_add;

  localparam int N = 8;

  logic           CLK;
  logic           RST;
  logic           valid;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [N-1:0]   addend;
  logic           busy;
  logic           ready;
  logic [2*N-1:0] result;

  unsigned_mul_add #(.N(N)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .valid        (valid),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .busy         (busy),
    .ready        (ready),
    .result       (result)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  int n_checks = 0;
  int n_fail   = 0;
  int completions = 0;
  bit pending = 1'b0;
  logic [15:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
    int t;
    t = a * b + c;
    return t[15:0];
  endfunction

  // Scoreboard monitor: result is written on the edge leaving DONE, so the
  // comparison happens one negedge after ready was seen.
  always @(negedge CLK) begin
    if (RST) begin
      sb.delete();
      pending = 1'b0;
    end else begin
      if (pending) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard underflow: got result 0x%0h, expected no completion", result);
        end else begin
          check("scoreboard result", 32'(result), 32'(sb.pop_front()));
          completions++;
        end
      end
      pending = ready;
      if (valid && !busy && !ready)
        sb.push_back(model(multiplicand, multiplier, addend));
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    @(posedge CLK); #1;
    for (int i = 0; i < 40; i++) begin
      if (!busy && !ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle timeout: got busy=%0b ready=%0b, expected idle", busy, ready);
    end
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready timeout: got ready=0, expected a ready pulse");
    end
  endtask

  // Start one operation with a single-cycle valid; returns aligned just
  // after the start edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    wait_idle();
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    valid        = 1'b1;
    @(posedge CLK); #1;
    valid = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [15:0] exp, input string name);
    start_op(a, b, c);
    wait_ready();
    @(posedge CLK); #1;
    check(name, 32'(result), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int n_ready;
    bit saw_ready;

    vecs[0] = '{8'd13,  8'd11,  8'd7,   16'h0096, "vec 13*11+7"};
    vecs[1] = '{8'd255, 8'd255, 8'd255, 16'hFF00, "vec max"};
    vecs[2] = '{8'd0,   8'd200, 8'd0,   16'h0000, "vec zero A"};
    vecs[3] = '{8'd7,   8'd28,  8'd4,   16'd200,  "vec divider round trip"};
    vecs[4] = '{8'd3,   8'd5,   8'd1,   16'd16,   "vec 3*5+1"};
    vecs[5] = '{8'd255, 8'd0,   8'd9,   16'd9,    "vec zero B"};
    vecs[6] = '{8'd0,   8'd0,   8'd255, 16'd255,  "vec addend only"};
    vecs[7] = '{8'd128, 8'd2,   8'd0,   16'd256,  "vec carry into hi"};
    vecs[8] = '{8'd200, 8'd200, 8'd100, 16'd40100, "vec 200*200+100"};
    vecs[9] = '{8'd1,   8'd255, 8'd255, 16'd510,  "vec 1*255+255"};

    RST = 1'b1;
    valid = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    addend       = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset ready", 32'(ready), 32'd0);
    check("reset result", 32'(result), 32'd0);

    // Cycle-accurate timing of the first operation.
    wait_idle();
    multiplicand = 8'd13;
    multiplier   = 8'd11;
    addend       = 8'd7;
    valid        = 1'b1;
    @(posedge CLK); #1;
    valid = 1'b0;
    for (int k = 0; k <= N + 2; k++) begin
      @(negedge CLK);
      check($sformatf("busy after edge %0d", k), 32'(busy), (k <= N) ? 32'd1 : 32'd0);
      check($sformatf("ready after edge %0d", k), 32'(ready), (k == N + 1) ? 32'd1 : 32'd0);
      check($sformatf("result after edge %0d", k), 32'(result),
            (k == N + 2) ? 32'h0096 : 32'h0000);
    end

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp, vecs[i].name);

    // valid held high: back-to-back operations every N+3 cycles.
    wait_idle();
    multiplicand = 8'd100;
    multiplier   = 8'd3;
    addend       = 8'd55;
    valid        = 1'b1;
    last = -1;
    n_ready = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (ready) begin
        n_ready++;
        if (last >= 0) check("ready interval", 32'(i - last), 32'(N + 3));
        last = i;
      end
      @(posedge CLK); #1;
      if (i == 39) valid = 1'b0;
    end
    check("held valid ready count", 32'(n_ready), 32'd4);

    // Operand changes during OP must not disturb the in-flight result.
    wait_idle();
    multiplicand = 8'd13;
    multiplier   = 8'd11;
    addend       = 8'd7;
    valid        = 1'b1;
    @(posedge CLK); #1;
    valid = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    multiplicand = 8'd255;
    multiplier   = 8'd255;
    addend       = 8'd255;
    valid        = 1'b1;
    wait_ready();
    @(posedge CLK); #1;
    check("in-flight result", 32'(result), 32'h0096);
    @(posedge CLK); #1;
    valid = 1'b0;
    wait_ready();
    @(posedge CLK); #1;
    check("next op new operands", 32'(result), 32'hFF00);

    // Reset in the middle of OP aborts the operation.
    start_op(8'd200, 8'd200, 8'd100);
    repeat (4) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort ready", 32'(ready), 32'd0);
    check("abort result", 32'(result), 32'd0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge CLK);
      if (ready) saw_ready = 1'b1;
    end
    check("no ready after abort", 32'(saw_ready), 32'd0);
    check("idle after abort", 32'(busy), 32'd0);
    check("result after abort", 32'(result), 32'd0);
    run_op(8'd3, 8'd5, 8'd1, 16'd16, "op after abort");

    repeat (3) @(posedge CLK);
    #1;
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    check("completion count", 32'(completions), 32'd18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
